// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max scheduler.
package minmax_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/minmax_pair.sv
// Two-operand unsigned compare: lo is the smaller operand, hi the larger.
module minmax_pair #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  assign lo = (x < y) ? x : y;
  assign hi = (x < y) ? y : x;

endmodule

// File: rtl/minmax_sched.sv
// Round-robin scheduler that computes min/max of four operands per request.
// Optional op_cnt handshake counter enabled by defining MINMAX_SCHED_CNT_EN.
module minmax_sched
  import minmax_pkg::*;
#(
  parameter int W    = 2,
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][4*W-1:0]   req_op,
  output logic [NREQ-1:0]            gnt,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [1:0]                 res_id,
  output logic [W-1:0]               res_min,
  output logic [W-1:0]               res_max,
`ifdef MINMAX_SCHED_CNT_EN
  output logic [7:0]                 op_cnt,
`endif
  output state_t                     state_dbg
);

  // Result handshake: res_valid is high for the whole DONE state and data is
  // held; a transfer happens on a clock edge where res_valid && res_ready.
  state_t         state, state_nxt;
  logic [1:0]     ptr, id_q, gnt_id, cand;
  logic           gnt_any;
  logic [W-1:0]   a_q, b_q, c_q, d_q;
  logic [W-1:0]   min_ab, min_cd, max_ab, max_cd;
  logic [W-1:0]   p0_x, p0_y, p1_x, p1_y;
  logic [W-1:0]   p0_lo, p0_hi, p1_lo, p1_hi;

  assign res_valid = (state == DONE);
  assign res_id    = id_q;
  assign state_dbg = state;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = ptr;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE: if (gnt_any && rst) begin
        gnt[gnt_id] = 1'b1;
        state_nxt   = S1;
      end
      S1:      state_nxt = S2;
      S2:      state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The two compare units are shared: pairwise stage in S1, reduction in S2.
  always_comb begin
    p0_x = (state == S2) ? min_ab : a_q;
    p0_y = (state == S2) ? min_cd : b_q;
    p1_x = (state == S2) ? max_ab : c_q;
    p1_y = (state == S2) ? max_cd : d_q;
  end

  minmax_pair #(.W(W)) u_pair0 (.x(p0_x), .y(p0_y), .lo(p0_lo), .hi(p0_hi));
  minmax_pair #(.W(W)) u_pair1 (.x(p1_x), .y(p1_y), .lo(p1_lo), .hi(p1_hi));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      min_ab  <= '0;
      max_ab  <= '0;
      min_cd  <= '0;
      max_cd  <= '0;
      res_min <= '0;
      res_max <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (gnt_any) begin
          ptr                  <= gnt_id;
          id_q                 <= gnt_id;
          {a_q, b_q, c_q, d_q} <= req_op[gnt_id];
        end
        S1: begin
          min_ab <= p0_lo;
          max_ab <= p0_hi;
          min_cd <= p1_lo;
          max_cd <= p1_hi;
        end
        S2: begin
          res_min <= p0_lo;
          res_max <= p1_hi;
        end
        default: ;
      endcase
    end
  end

`ifdef MINMAX_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   op_cnt <= '0;
    else if (res_valid && res_ready) op_cnt <= op_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_minmax_sched.sv
// Directed self-checking bench for minmax_sched (define MINMAX_SCHED_CNT_EN to cover op_cnt).
module tb_minmax_sched;
  import minmax_pkg::*;

  localparam int W = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [3:0]               req = '0;
  logic [3:0][4*W-1:0]      req_op = '0;
  logic [3:0]               gnt;
  logic                     res_valid;
  logic                     res_ready = 1'b0;
  logic [1:0]               res_id;
  logic [W-1:0]             res_min;
  logic [W-1:0]             res_max;
  state_t                   state_dbg;
`ifdef MINMAX_SCHED_CNT_EN
  logic [7:0]               op_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  minmax_sched #(.W(W), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_min   (res_min),
    .res_max   (res_max),
`ifdef MINMAX_SCHED_CNT_EN
    .op_cnt    (op_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver helpers: advance to just after the next falling edge, or let comb logic settle.
  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [7:0] ops(input int a, input int b, input int c, input int d);
    return {2'(a), 2'(b), 2'(c), 2'(d)};
  endfunction

  task automatic check_res(input string tag, input int id, input int mn, input int mx);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_id"},    res_id,    id);
    check({tag, "_min"},   res_min,   mn);
    check({tag, "_max"},   res_max,   mx);
  endtask

  int exp_min[4] = '{0, 2, 1, 0};
  int exp_max[4] = '{3, 2, 3, 1};

  initial begin
    logic [3:0] e;
    int id;

    // Reset state, with requests present that must not be granted
    req = 4'b1111;
    req_op[0] = ops(3, 1, 2, 0);
    req_op[1] = ops(2, 2, 2, 2);
    req_op[2] = ops(1, 3, 3, 1);
    req_op[3] = ops(0, 0, 1, 0);
    nc();
    nc();
    check("rst_gnt",   gnt,       0);
    check("rst_valid", res_valid, 0);
    check("rst_id",    res_id,    0);
    check("rst_min",   res_min,   0);
    check("rst_max",   res_max,   0);
    check("rst_state", state_dbg, IDLE);
    req = '0;
    settle();
    rst = 1'b1;

    // Single operation, latency check
    nc();
    check("idle_nogrant", gnt, 0);
    req = 4'b0001;
    res_ready = 1'b1;
    settle();
    check("t1_gnt", gnt, 4'b0001);
    nc();
    req = '0;
    settle();
    check("t1_valid_n1", res_valid, 0);
    nc();
    check("t1_valid_n2", res_valid, 0);
    nc();
    check_res("t1", 0, 0, 3);
    nc();
    check("t1_back_idle", state_dbg, IDLE);

    // Round robin with all requests held, fresh pointer after reset
    rst = 1'b0;
    settle();
    nc();
    rst = 1'b1;
    req = 4'b1111;
    settle();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int g = 0; g < 5; g++) begin
      e  = exp_q.pop_front();
      id = g % 4;
      check("rr_gnt", gnt, e);
      for (int c = 1; c <= 3; c++) begin
        nc();
        if (g == 4 && c == 1) begin
          req = '0;
          settle();
        end
        check("rr_gap_gnt", gnt, 0);
        if (c < 3) check("rr_pipe_valid", res_valid, 0);
      end
      check_res("rr", id, exp_min[id], exp_max[id]);
      nc();
    end
    check("rr_idle", state_dbg, IDLE);

    // Back-pressure in DONE; requests must be ignored until the handshake
    res_ready = 1'b0;
    req_op[0] = ops(1, 2, 0, 3);
    req = 4'b0001;
    settle();
    check("bp_gnt", gnt, 4'b0001);
    nc();
    req = 4'b1110;
    settle();
    check("bp_s1_gnt", gnt, 0);
    nc();
    check("bp_s2_gnt", gnt, 0);
    nc();
    for (int k = 0; k < 5; k++) begin
      check_res("bp_hold", 0, 0, 3);
      check("bp_hold_gnt", gnt, 0);
      nc();
    end
    res_ready = 1'b1;
    settle();
    check_res("bp_release", 0, 0, 3);
    nc();
    check("bp_successor", gnt, 4'b0010);

    // Reset in S2 aborts the operation; lowest pending index wins afterwards
    nc();
    req = 4'b1010;
    settle();
    check("ab_s1_gnt", gnt, 0);
    nc();
    check("ab_in_s2", state_dbg, S2);
    check("ab_pre_max", res_max, 3);
    rst = 1'b0;
    settle();
    check("ab_gnt",   gnt,       0);
    check("ab_valid", res_valid, 0);
    check("ab_id",    res_id,    0);
    check("ab_min",   res_min,   0);
    check("ab_max",   res_max,   0);
    check("ab_state", state_dbg, IDLE);
    nc();
    rst = 1'b1;
    settle();
    check("ab_first_gnt", gnt, 4'b0010);
    nc();
    req = '0;
    nc();
    nc();
    check_res("ab_res", 1, 2, 2);
    nc();

`ifdef MINMAX_SCHED_CNT_EN
    // Operation counter wraps after 256 handshakes
    begin
      int hs_n;
      int cyc;
      rst = 1'b0;
      settle();
      check("cnt_rst", op_cnt, 0);
      nc();
      rst = 1'b1;
      req = 4'b0001;
      res_ready = 1'b1;
      settle();
      hs_n = 0;
      cyc  = 0;
      while (hs_n < 257 && cyc < 3000) begin
        if (res_valid && res_ready) hs_n++;
        nc();
        cyc++;
      end
      check("cnt_ops_done", hs_n, 257);
      check("cnt_wrap", op_cnt, 1);
      req = '0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minmax_sched.md
MINMAX_SCHED -- requirements
Module: minmax_sched

Interface
REQ-001 The block SHALL have parameter W, default 2, giving the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, fixed at 4, giving the number of requesters.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port req  input  NREQ  SHALL carry per-requester request flags; req[i] is held until gnt[i].
REQ-006 Port req_op  input  NREQ x 4W  SHALL carry per-requester operands {a,b,c,d}, with a in the MSBs.
REQ-007 Port gnt  output  NREQ  SHALL carry a one-hot, single-cycle grant that accepts req_op[i].
REQ-008 Port res_valid  output  1  SHALL flag a result available.
REQ-009 Port res_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-010 Port res_id  output  2  SHALL carry the index of the requester that owns the result.
REQ-011 Port res_min  output  W  SHALL carry the minimum of a, b, c and d.
REQ-012 Port res_max  output  W  SHALL carry the maximum of a, b, c and d.

Function
REQ-013 The FSM SHALL have the states IDLE, S1, S2 and DONE, and exactly one operation SHALL be in flight at a time.
REQ-014 In IDLE with any req bit set, the block SHALL assert gnt for exactly one requester for one cycle, latch that requester's operands and id, and go to S1.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with gnt == 0.
REQ-016 Arbitration SHALL be round-robin, searching from ptr+1 mod 4 upward; ptr updates to the granted index on each grant.
REQ-017 In S1, the block SHALL register min(a,b), min(c,d), max(a,b) and max(c,d), then go to S2.
REQ-018 In S2, the block SHALL register the min of the two mins and the max of the two maxes, then go to DONE.
REQ-019 Comparisons SHALL be unsigned; equal operands yield that value for both min and max.
REQ-020 In DONE, res_valid SHALL be 1 and res_min, res_max and res_id SHALL be stable until the handshake.
REQ-021 When res_valid and res_ready are both 1, the block SHALL go to IDLE; otherwise it stays in DONE.
REQ-022 Latency SHALL be: grant in cycle N, then res_valid first high in cycle N+3.
REQ-023 The minimum grant-to-grant spacing SHALL be 4 cycles, with the next grant in the cycle after the handshake.
REQ-024 req changes while not in IDLE SHALL be ignored and gnt SHALL be 0 outside IDLE.
REQ-025 res_ready while res_valid == 0 SHALL have no effect.

Reset
REQ-026 While rst is low, the block SHALL force state IDLE, ptr = 3 (so req[0] wins first), all pipeline registers to 0, gnt = 0, res_valid = 0, res_id = 0, res_min = 0 and res_max = 0.
REQ-027 Reset asserted mid-operation SHALL abort it silently; the lost request is not re-granted unless req is still high after reset.

Configuration
REQ-028 With MINMAX_SCHED_CNT_EN defined, the block SHALL add output op_cnt[7:0], which resets to 0, increments on each res handshake and wraps from 255 to 0.
REQ-029 Without MINMAX_SCHED_CNT_EN, the op_cnt port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package minmax_pkg SHALL hold the state enum type (IDLE, S1, S2, DONE) and the constant NREQ = 4.
REQ-031 The two-operand compare SHALL be a sub-module minmax_pair (inputs x and y, outputs lo and hi, combinational), instanced for S1 and S2.

Verification
REQ-032 The bench SHALL drive rst low, then release it, then req = 0001 with req_op[0] = {3,1,2,0} and check gnt = 0001, then res_valid in N+3 with res_min = 0, res_max = 3 and res_id = 0.
REQ-033 The bench SHALL drive req = 1111 held continuously with res_ready = 1 and check the grant order 0,1,2,3,0 with grant spacing of 4 cycles.
REQ-034 The bench SHALL drive all operands equal to 2 and check that res_min = 2 and res_max = 2.
REQ-035 The bench SHALL drive res_ready = 0 for 5 cycles in DONE and check that res_valid and the data are held, gnt = 0 despite req = 1110, then after ready the next grant goes to the round-robin successor.
REQ-036 The bench SHALL pull rst low during S2 and check that all outputs go to 0 immediately, then after release the first grant goes to the lowest pending index.
REQ-037 With MINMAX_SCHED_CNT_EN defined, the bench SHALL complete 257 operations and check op_cnt = 1.
